// File: rtl/trojan_chk_pkg.sv
// trojan_chk_pkg: shared state encoding and default pattern width for the response checker.
package trojan_chk_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
    localparam int N_IN_DEFAULT = 5;
endpackage

// File: rtl/trojan_response_checker_golden_mem.sv
// golden_mem: DEPTH x 1 golden truth table, synchronous write, combinational read.
module golden_mem #(
    parameter int N_IN = 5
) (
    input  logic            CK,
    input  logic            we,
    input  logic [N_IN-1:0] waddr,
    input  logic            wdata,
    input  logic [N_IN-1:0] raddr,
    output logic            rdata
);
    logic [2**N_IN-1:0] mem;

    always_ff @(posedge CK)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/trojan_response_checker.sv
// trojan_response_checker: loads a golden truth table, then scores observed responses against it.
module trojan_response_checker
    import trojan_chk_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) (
    input  logic            CK,
    input  logic            reset,
    input  logic            start,
    input  logic            gold_valid,
    input  logic            gold_bit,
    output logic            gold_ready,
    input  logic            obs_valid,
    input  logic [N_IN-1:0] obs_pattern,
    input  logic            obs_resp,
    output logic            obs_ready,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_pattern,
    output logic [N_IN:0]   covered_cnt
);
    localparam int DEPTH = 2**N_IN;
    localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};

    state_t            state;
    logic [N_IN-1:0]   load_ptr;
    logic [DEPTH-1:0]  cov;
    logic              gold_rd;
    logic              miss;
    logic              fresh;

    golden_mem #(.N_IN(N_IN)) u_mem (
        .CK   (CK),
        .we   (gold_valid && state == LOAD),
        .waddr(load_ptr),
        .wdata(gold_bit),
        .raddr(obs_pattern),
        .rdata(gold_rd)
    );

    assign gold_ready = state == LOAD;
    assign obs_ready  = state == CHECK;
    assign busy       = gold_ready || obs_ready;
    assign done       = state == DONE;
    assign pass       = done && mismatch_cnt == '0;
    assign miss       = obs_resp != gold_rd;
    assign fresh      = !cov[obs_pattern];

    always_ff @(posedge CK) begin
        if (!reset) begin
            state              <= IDLE;
            load_ptr           <= '0;
            cov                <= '0;
            covered_cnt        <= '0;
            mismatch_cnt       <= '0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state              <= LOAD;
                    load_ptr           <= '0;
                    cov                <= '0;
                    covered_cnt        <= '0;
                    mismatch_cnt       <= '0;
                    first_fail_valid   <= 1'b0;
                    first_fail_pattern <= '0;
                end
                LOAD: if (gold_valid) begin
                    load_ptr <= load_ptr + 1'b1;
                    if (load_ptr == '1) state <= CHECK;
                end
                CHECK: if (obs_valid) begin
                    if (miss) begin
                        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid   <= 1'b1;
                            first_fail_pattern <= obs_pattern;
                        end
                    end
                    // duplicates are re-scored but never advance coverage
                    if (fresh) begin
                        cov[obs_pattern] <= 1'b1;
                        covered_cnt      <= covered_cnt + 1'b1;
                        if (covered_cnt == LAST) state <= DONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trojan_response_checker.sv
// tb_trojan_response_checker: directed checks of load, scoring, coverage, restart and reset.
module tb_trojan_response_checker;
    logic       CK = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       gold_valid = 1'b0;
    logic       gold_bit = 1'b0;
    logic       gold_ready;
    logic       obs_valid = 1'b0;
    logic [4:0] obs_pattern = '0;
    logic       obs_resp = 1'b0;
    logic       obs_ready;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] mismatch_cnt;
    logic       first_fail_valid;
    logic [4:0] first_fail_pattern;
    logic [5:0] covered_cnt;
    int checks = 0;
    int errors = 0;

    trojan_response_checker #(.N_IN(5)) dut (
        .CK(CK), .reset(reset), .start(start),
        .gold_valid(gold_valid), .gold_bit(gold_bit), .gold_ready(gold_ready),
        .obs_valid(obs_valid), .obs_pattern(obs_pattern), .obs_resp(obs_resp), .obs_ready(obs_ready),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_pattern(first_fail_pattern),
        .covered_cnt(covered_cnt)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_parity();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] p;
            p = 5'(i);
            gold_valid = 1'b1;
            gold_bit = ^p;
            tick();
        end
        gold_valid = 1'b0;
    endtask

    task automatic observe(input logic [4:0] p, input logic r);
        obs_valid = 1'b1;
        obs_pattern = p;
        obs_resp = r;
        tick();
        obs_valid = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_outputs", {gold_ready, obs_ready, busy, done, pass, first_fail_valid}, 6'b0);
        check("rst_counts", {mismatch_cnt, first_fail_pattern, covered_cnt}, 17'b0);

        // test 1: clean parity run, with a stray observation inside LOAD
        pulse_start();
        check("load_ready", {gold_ready, obs_ready, busy}, 3'b101);
        observe(5'd7, 1'b1);
        check("load_obs_ignored", {gold_ready, obs_ready, mismatch_cnt, covered_cnt}, {2'b10, 12'd0});
        load_parity();
        check("check_entered", {gold_ready, obs_ready, busy}, 3'b011);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] p;
            p = 5'(i);
            observe(p, ^p);
            if (i == 0) check("cov_after_first", covered_cnt, 1);
            if (i == 30) check("not_done_31", done, 0);
        end
        check("clean_done", {done, pass, busy}, 3'b110);
        check("clean_cov", covered_cnt, 32);
        check("clean_miss", {mismatch_cnt, first_fail_valid}, 7'b0);
        observe(5'd1, 1'b0);
        check("done_obs_ignored", {mismatch_cnt, done}, {6'd0, 1'b1});

        // test 2: two flipped responses, plus a start pulse mid-CHECK
        pulse_start();
        check("restart_clear", {done, covered_cnt, mismatch_cnt}, 13'b0);
        load_parity();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] p;
            p = 5'(i);
            observe(p, (p == 5'b01101 || p == 5'b10110) ? ~^p : ^p);
            if (i == 4) begin
                pulse_start();
                check("start_in_check", {obs_ready, gold_ready, covered_cnt}, {2'b10, 6'd5});
            end
        end
        check("flip_miss", mismatch_cnt, 2);
        check("flip_first", {first_fail_valid, first_fail_pattern}, {1'b1, 5'b01101});
        check("flip_verdict", {done, pass}, 2'b10);

        // test 3: duplicates scored but not covered
        pulse_start();
        load_parity();
        repeat (3) observe(5'b00011, 1'b1);
        check("dup_miss", mismatch_cnt, 3);
        check("dup_cov", covered_cnt, 1);
        check("dup_first", {first_fail_valid, first_fail_pattern}, {1'b1, 5'b00011});
        for (int i = 0; i < 32; i++) begin
            logic [4:0] p;
            p = 5'(i);
            if (p != 5'b00011) observe(p, ^p);
            if (i == 30) check("dup_not_done", {done, covered_cnt}, {1'b0, 6'd31});
        end
        check("dup_final", {done, pass, mismatch_cnt, covered_cnt}, {2'b10, 6'd3, 6'd32});

        // test 4: reset mid-CHECK, with start held so reset must win
        pulse_start();
        load_parity();
        for (int i = 0; i < 10; i++) begin
            logic [4:0] p;
            p = 5'(i);
            observe(p, ~^p);
        end
        check("pre_reset", {covered_cnt, mismatch_cnt}, {6'd10, 6'd10});
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_reset", {busy, obs_ready, gold_ready, done, first_fail_valid}, 5'b0);
        check("mid_reset_cnt", {covered_cnt, mismatch_cnt}, 12'b0);
        reset = 1'b1;
        tick();
        check("reset_idle", busy, 0);
        pulse_start();
        load_parity();
        for (int i = 31; i >= 0; i--) begin
            logic [4:0] p;
            p = 5'(i);
            observe(p, ^p);
        end
        check("reload_pass", {done, pass, mismatch_cnt, covered_cnt}, {2'b11, 6'd0, 6'd32});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trojan_response_checker.md
# trojan_response_checker

Synthesizable response checker for the trojan-detection flow. It first loads a golden truth table for an N_IN-input, single-output circuit under test. It then consumes (pattern, response) observations, compares each against the golden table, and reports mismatch count, first failing pattern, input-space coverage and a pass/fail verdict. It sits at the reading end of the exhaustive-pattern stimulus path that drives the circuit under test.

## Interface
- N_IN, default 5, input pattern width; DEPTH = 2**N_IN golden entries
- CK  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on CK rising edge
- start  in  1  pulse; accepted in IDLE or DONE only
- gold_valid  in  1  golden bit present
- gold_bit  in  1  expected output for entry gold load pointer
- gold_ready  out  1  high only in LOAD
- obs_valid  in  1  observation present
- obs_pattern  in  N_IN  applied input pattern
- obs_resp  in  1  observed output_single
- obs_ready  out  1  high only in CHECK
- busy  out  1  high in LOAD or CHECK
- done  out  1  high in DONE
- pass  out  1  done && mismatch_cnt==0
- mismatch_cnt  out  N_IN+1  saturating mismatch counter
- first_fail_valid  out  1  a mismatch has been recorded
- first_fail_pattern  out  N_IN  pattern of first mismatch
- covered_cnt  out  N_IN+1  distinct patterns observed (0..DEPTH)

## Operation
- FSM states IDLE, LOAD, CHECK, DONE; reset -> IDLE.
- Transitions:
  - IDLE/DONE + start -> LOAD. Clears load pointer, coverage bitmap, covered_cnt, mismatch_cnt, first_fail_*.
  - LOAD: each gold_valid&&gold_ready writes gold_bit to golden[load_ptr], then load_ptr++. The write of entry DEPTH-1 -> CHECK.
  - CHECK: each obs_valid&&obs_ready compares obs_resp with golden[obs_pattern].
    - On mismatch, mismatch_cnt++, saturating at 2**(N_IN+1)-1.
    - If first_fail_valid==0, capture obs_pattern and set first_fail_valid.
    - If the coverage bit is clear, set it and increment covered_cnt.
  - CHECK -> DONE in the cycle covered_cnt becomes DEPTH.
- Duplicate patterns are re-compared and may add mismatches. They never increase covered_cnt.
- start in LOAD/CHECK is ignored. obs_valid outside CHECK and gold_valid outside LOAD are ignored, with no side effects.
- Golden table contents survive restart and are overwritten by the next LOAD. The coverage bitmap is cleared on start.
- Reset values: gold_ready=0, obs_ready=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_valid=0, first_fail_pattern=0, covered_cnt=0, FSM=IDLE.

## Timing
- gold_ready, obs_ready, busy and done are decoded from registered state only; no combinational path from inputs.
- One transfer per cycle maximum on each channel; back-to-back transfers are allowed at full rate.
- Minimum LOAD duration: DEPTH cycles. Minimum CHECK duration: DEPTH cycles.
- Observation results (mismatch_cnt, first_fail_*, covered_cnt) are visible the cycle after the accepting edge.
- done rises the cycle after the accept that completes coverage.
- Reset asserted mid-LOAD or mid-CHECK returns to IDLE at the next edge and clears all outputs. The golden contents become don't-care.
- start and reset low in the same cycle: reset wins.

## Structure
- Package trojan_chk_pkg holds the state enum (IDLE, LOAD, CHECK, DONE) and the default N_IN constant.
- Sub-module golden_mem: DEPTH x 1 register file with one synchronous write port and one combinational read port. It is written in LOAD and read in CHECK.
- The top level holds the FSM, load pointer, coverage bitmap (DEPTH flops), counters and first-fail capture.

## Test plan
- Reset, then idle 3 cycles -> all outputs 0, gold_ready=0, obs_ready=0.
- Load golden = parity of 5-bit pattern, then observe 00000..11111 with correct responses -> done after 32 accepts, covered_cnt=32, mismatch_cnt=0, pass=1.
- Same load; flip the response for 01101 and 10110 -> mismatch_cnt=2, first_fail_pattern=01101, pass=0.
- Observe 00011 three times, all wrong, then all remaining patterns correctly -> mismatch_cnt=3, covered_cnt=32, done only after the 32nd distinct pattern.
- Drop reset low mid-CHECK after 10 accepts -> next cycle IDLE, covered_cnt=0, mismatch_cnt=0. A following start reloads cleanly.
- Pulse start during CHECK and assert obs_valid during LOAD -> no state change, no counter change; obs_ready stays 0 in LOAD.
